// File: rtl/nibble_serial_subtractor_pkg.sv
// Shared types and constants for the nibble-serial subtractor.
package sub_pkg;

  localparam int NIBBLE_W = 4;

  typedef enum logic [1:0] {
    IDLE = 2'd0,
    RUN  = 2'd1,
    DONE = 2'd2
  } sub_state_t;

endpackage

// File: rtl/nibble_serial_subtractor_cla_slice4.sv
// 4-bit carry-lookahead adder slice (pure combinational).
module cla_slice4 (
  input  logic [3:0] a4,
  input  logic [3:0] b4,
  input  logic       cin,
  output logic [3:0] s4,
  output logic       cout
);

  logic [3:0] g;
  logic [3:0] p;
  logic [4:0] c;

  assign g = a4 & b4;
  assign p = a4 ^ b4;

  // Carries expanded directly from generate/propagate rather than rippled.
  assign c[0] = cin;
  assign c[1] = g[0] | (p[0] & cin);
  assign c[2] = g[1] | (p[1] & g[0]) | (p[1] & p[0] & cin);
  assign c[3] = g[2] | (p[2] & g[1]) | (p[2] & p[1] & g[0])
              | (p[2] & p[1] & p[0] & cin);
  assign c[4] = g[3] | (p[3] & g[2]) | (p[3] & p[2] & g[1])
              | (p[3] & p[2] & p[1] & g[0]) | (p[3] & p[2] & p[1] & p[0] & cin);

  assign s4   = p ^ c[3:0];
  assign cout = c[4];

endmodule

// File: rtl/nibble_serial_subtractor.sv
// Multi-cycle a - b, one nibble per clock (LSB first) through one CLA slice.
//
// state | meaning
// ------+----------------------------------------------------------
// IDLE  | waiting for start; last result (if any) held
// RUN   | one nibble of a + ~b + carry per cycle, busy high
// DONE  | one-cycle done pulse; flags valid; start may re-accept here
module nibble_serial_subtractor
  import sub_pkg::*;
#(
  parameter int WIDTH = 16  // multiple of 4, at least 8
) (
  input  logic             clk,
  input  logic             reset,
  input  logic             start,
  input  logic [WIDTH-1:0] a,
  input  logic [WIDTH-1:0] b,
  output logic             busy,
  output logic             done,
  output logic [WIDTH-1:0] diff,
  output logic             borrow,
  output logic             overflow,
  output logic             zero
);

  localparam int NIB   = WIDTH / NIBBLE_W;
  // One extra bit so the index never wraps back to zero.
  localparam int IDX_W = $clog2(NIB) + 1;
  localparam logic [IDX_W-1:0] LAST_IDX = IDX_W'(NIB - 1);

  sub_state_t          state_q;
  logic [WIDTH-1:0]    a_q;
  logic [WIDTH-1:0]    b_q;
  logic [WIDTH-1:0]    diff_q;
  logic [IDX_W-1:0]    idx_q;
  logic                carry_q;

  logic [NIBBLE_W-1:0] a_nib;
  logic [NIBBLE_W-1:0] b_nib;
  logic [NIBBLE_W-1:0] b_nib_inv;
  logic [NIBBLE_W-1:0] sum4;
  logic                cout;
  logic                accept;

  assign accept    = start && (state_q == IDLE || state_q == DONE);
  assign b_nib_inv = ~b_nib;

  // Select the current operand nibbles from the latched operands.
  always_comb begin
    a_nib = '0;
    b_nib = '0;
    for (int i = 0; i < NIB; i++) begin
      if (idx_q == IDX_W'(i)) begin
        a_nib = a_q[i*NIBBLE_W +: NIBBLE_W];
        b_nib = b_q[i*NIBBLE_W +: NIBBLE_W];
      end
    end
  end

  cla_slice4 u_cla (
    .a4   (a_nib),
    .b4   (b_nib_inv),
    .cin  (carry_q),
    .s4   (sum4),
    .cout (cout)
  );

  // FSM, operand latch, carry, nibble index, diff register and flags.
  always_ff @(posedge clk or posedge reset) begin
    if (reset) begin
      state_q  <= IDLE;
      a_q      <= '0;
      b_q      <= '0;
      diff_q   <= '0;
      idx_q    <= '0;
      carry_q  <= 1'b0;
      busy     <= 1'b0;
      done     <= 1'b0;
      borrow   <= 1'b0;
      overflow <= 1'b0;
      zero     <= 1'b0;
    end else begin
      if (accept) begin
        state_q  <= RUN;
        a_q      <= a;
        b_q      <= b;
        diff_q   <= '0;
        idx_q    <= '0;
        carry_q  <= 1'b1;   // the +1 of a + ~b + 1
        busy     <= 1'b1;
        done     <= 1'b0;
        borrow   <= 1'b0;
        overflow <= 1'b0;
        zero     <= 1'b0;
      end else begin
        case (state_q)
          RUN: begin
            for (int i = 0; i < NIB; i++) begin
              if (idx_q == IDX_W'(i)) diff_q[i*NIBBLE_W +: NIBBLE_W] <= sum4;
            end
            carry_q <= cout;
            idx_q   <= idx_q + 1'b1;
            if (idx_q == LAST_IDX) begin
              // Flags use this cycle's slice outputs: sum4 is the MSB nibble.
              state_q  <= DONE;
              busy     <= 1'b0;
              done     <= 1'b1;
              borrow   <= ~cout;
              overflow <= (a_q[WIDTH-1] != b_q[WIDTH-1]) && (sum4[NIBBLE_W-1] != a_q[WIDTH-1]);
              zero     <= (diff_q[WIDTH-NIBBLE_W-1:0] == '0) && (sum4 == '0);
            end
          end
          DONE: begin
            state_q <= IDLE;
            done    <= 1'b0;
          end
          default: begin
            state_q <= IDLE;
            done    <= 1'b0;
          end
        endcase
      end
    end
  end

  assign diff = diff_q;

endmodule

// File: tb/tb_nibble_serial_subtractor.sv
// Directed testbench for nibble_serial_subtractor (WIDTH = 16).
module tb_nibble_serial_subtractor;

  logic        clk;
  logic        reset;
  logic        start;
  logic [15:0] a_in;
  logic [15:0] b_in;
  logic        busy;
  logic        done;
  logic [15:0] diff;
  logic        borrow;
  logic        overflow;
  logic        zero;

  int checks;
  int failures;
  int lat;

  nibble_serial_subtractor #(.WIDTH(16)) dut (
    .clk      (clk),
    .reset    (reset),
    .start    (start),
    .a        (a_in),
    .b        (b_in),
    .busy     (busy),
    .done     (done),
    .diff     (diff),
    .borrow   (borrow),
    .overflow (overflow),
    .zero     (zero)
  );

  initial clk = 1'b0;
  always #5 clk = ~clk;

  task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    checks++;
    assert (obs === exp)
    else begin
      failures++;
      $error("FAIL %s observed=%0h expected=%0h", tag, obs, exp);
    end
  endtask

  // Called away from an edge; returns #1 after the accepting edge.
  task automatic start_op(input string tag, input logic [15:0] av, input logic [15:0] bv);
    a_in  = av;
    b_in  = bv;
    start = 1'b1;
    @(posedge clk);
    #1;
    start = 1'b0;
    chk({tag, "_accept_busy"}, 32'(busy), 32'd1);
    chk({tag, "_accept_done"}, 32'(done), 32'd0);
    chk({tag, "_accept_diff_clr"}, 32'(diff), 32'd0);
  endtask

  // Counts edges since accept until done is seen (bounded).
  task automatic wait_done(input string tag, input int already, output int n);
    n = already;
    while (done !== 1'b1 && n < 20) begin
      @(posedge clk);
      #1;
      n++;
    end
    chk({tag, "_latency"}, 32'(n), 32'd4);
  endtask

  task automatic chk_result(input string tag, input logic [15:0] d, input logic bo,
                            input logic ov, input logic z);
    chk({tag, "_diff"}, 32'(diff), 32'(d));
    chk({tag, "_borrow"}, 32'(borrow), 32'(bo));
    chk({tag, "_overflow"}, 32'(overflow), 32'(ov));
    chk({tag, "_zero"}, 32'(zero), 32'(z));
    chk({tag, "_busy_in_done"}, 32'(busy), 32'd0);
  endtask

  task automatic chk_idle_after(input string tag, input logic [15:0] d);
    @(posedge clk);
    #1;
    chk({tag, "_done_pulse_end"}, 32'(done), 32'd0);
    chk({tag, "_idle_busy"}, 32'(busy), 32'd0);
    chk({tag, "_hold_diff"}, 32'(diff), 32'(d));
  endtask

  initial begin
    checks   = 0;
    failures = 0;
    reset    = 1'b1;
    start    = 1'b0;
    a_in     = '0;
    b_in     = '0;

    #2;
    chk("rst_busy", 32'(busy), 32'd0);
    chk("rst_done", 32'(done), 32'd0);
    chk("rst_diff", 32'(diff), 32'd0);
    chk("rst_flags", {29'd0, borrow, overflow, zero}, 32'd0);
    @(negedge clk);
    reset = 1'b0;
    @(negedge clk);

    start_op("t1", 16'h1234, 16'h0234);
    wait_done("t1", 0, lat);
    chk_result("t1", 16'h1000, 1'b0, 1'b0, 1'b0);
    chk_idle_after("t1", 16'h1000);

    start_op("t2", 16'h1000, 16'h0001);
    wait_done("t2", 0, lat);
    chk_result("t2", 16'h0FFF, 1'b0, 1'b0, 1'b0);
    chk_idle_after("t2", 16'h0FFF);

    start_op("t3", 16'h0000, 16'h0001);
    wait_done("t3", 0, lat);
    chk_result("t3", 16'hFFFF, 1'b1, 1'b0, 1'b0);
    chk_idle_after("t3", 16'hFFFF);

    start_op("t4", 16'h8000, 16'h0001);
    wait_done("t4", 0, lat);
    chk_result("t4", 16'h7FFF, 1'b0, 1'b1, 1'b0);
    chk_idle_after("t4", 16'h7FFF);

    start_op("t5", 16'h7FFF, 16'hFFFF);
    wait_done("t5", 0, lat);
    chk_result("t5", 16'h8000, 1'b1, 1'b1, 1'b0);
    chk_idle_after("t5", 16'h8000);

    // Equal operands, then back-to-back start during the done cycle.
    start_op("t6", 16'hBEEF, 16'hBEEF);
    wait_done("t6", 0, lat);
    chk_result("t6", 16'h0000, 1'b0, 1'b0, 1'b1);
    start_op("t6b", 16'h0005, 16'h0003);
    chk("t6b_flags_clr", {29'd0, borrow, overflow, zero}, 32'd0);
    wait_done("t6b", 0, lat);
    chk_result("t6b", 16'h0002, 1'b0, 1'b0, 1'b0);
    chk_idle_after("t6b", 16'h0002);

    // start and operand changes during RUN are ignored.
    start_op("t7", 16'h00F0, 16'h000F);
    @(posedge clk);
    #1;
    start = 1'b1;
    a_in  = 16'hFFFF;
    b_in  = 16'h0000;
    @(posedge clk);
    #1;
    start = 1'b0;
    chk("t7_still_busy", 32'(busy), 32'd1);
    chk("t7_no_early_done", 32'(done), 32'd0);
    wait_done("t7", 2, lat);
    chk_result("t7", 16'h00E1, 1'b0, 1'b0, 1'b0);
    chk_idle_after("t7", 16'h00E1);

    // Asynchronous reset between edges in the middle of RUN.
    start_op("t8", 16'h5555, 16'h1111);
    @(posedge clk);
    #3;
    reset = 1'b1;
    #1;
    chk("t8_rst_busy", 32'(busy), 32'd0);
    chk("t8_rst_done", 32'(done), 32'd0);
    chk("t8_rst_diff", 32'(diff), 32'd0);
    @(negedge clk);
    reset = 1'b0;
    @(posedge clk);
    #1;
    @(posedge clk);
    #1;
    chk("t8_idle_busy", 32'(busy), 32'd0);
    chk("t8_idle_done", 32'(done), 32'd0);
    start_op("t9", 16'h5555, 16'h1111);
    wait_done("t9", 0, lat);
    chk_result("t9", 16'h4444, 1'b0, 1'b0, 1'b0);
    chk_idle_after("t9", 16'h4444);

    $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
    $finish;
  end

endmodule

// File: doc/nibble_serial_subtractor.md
# nibble_serial_subtractor

Multi-cycle WIDTH-bit two's-complement subtractor computing a − b one 4-bit nibble per clock, LSB nibble first, through a single 4-bit carry-lookahead slice. It is the inverse-operation companion to the team's 4-bit carry-lookahead adder. It serves datapaths where area matters more than latency. A start/busy/done handshake is used, and results are held until the next operation.

## Interface
- WIDTH, 16, operand/result width; must be a multiple of 4 and ≥ 8
- clk  input  1  clock, all state on rising edge
- reset  input  1  asynchronous, active-high reset
- start  input  1  request; sampled only in IDLE or DONE
- a  input  WIDTH  minuend; sampled on the accepting edge only
- b  input  WIDTH  subtrahend; sampled on the accepting edge only
- busy  output  1  high while in RUN
- done  output  1  one-cycle pulse in DONE
- diff  output  WIDTH  a − b modulo 2^WIDTH
- borrow  output  1  1 when unsigned a < b
- overflow  output  1  signed two's-complement overflow of a − b
- zero  output  1  1 when diff == 0

## Operation
- Uses a + ~b + 1. The carry register is preset to 1 on accept.
- Define NIB = WIDTH/4.
- States: IDLE, RUN, DONE.
  - IDLE → RUN on start=1.
  - RUN → DONE after NIB nibble steps.
  - DONE → RUN if start=1, else DONE → IDLE.
- Accept edge (start=1 in IDLE or DONE):
  - Latch a and b into operand registers.
  - Set carry = 1 and nibble index = 0.
  - Clear the diff working register.
- RUN step k (k = 0..NIB−1):
  - sum4 = a[4k+3:4k] + ~b[4k+3:4k] + carry, computed through the 4-bit CLA slice.
  - Write diff[4k+3:4k] = sum4 and set carry = slice carry-out.
  - Increment the index. It is log2(NIB)+1 bits wide so it cannot wrap.
- On entering DONE:
  - borrow = ~carry (final carry-out inverted).
  - overflow = (a[MSB] ≠ b[MSB]) & (diff[MSB] ≠ a[MSB]), using the latched operands.
  - zero = (diff == 0).
- start while busy=1 is ignored. There is no queueing, and a and b changes during RUN have no effect.
- diff, borrow, overflow and zero are registered.
  - They are valid from the done cycle onward.
  - They hold until the next accept edge. On accept, diff clears, and borrow, overflow and zero clear.
- Reset (asynchronous, any time, including mid-RUN):
  - State = IDLE, busy = 0, done = 0, diff = 0, borrow = 0, overflow = 0, zero = 0, carry = 0, index = 0.
  - A partial result is discarded.

## Timing
- Accept on edge E0. busy = 1 from E0 to edge E_NIB.
- Nibble k is registered on edge E(k+1).
- done is high for exactly one cycle, between edges E_NIB and E_NIB+1. Latency is NIB cycles (4 for WIDTH = 16).
- Back-to-back: start=1 during the done cycle is accepted on E_NIB+1. busy rises immediately with no IDLE gap. Throughput is one result per NIB+1 cycles.
- The combinational path is confined to one 4-bit CLA slice plus carry register setup.
- No output depends combinationally on any input.

## Structure
- Shared package `sub_pkg`:
  - State enum `sub_state_t` {IDLE, RUN, DONE}.
  - Constant NIBBLE_W = 4.
- Sub-module `cla_slice4`:
  - Pure combinational 4-bit generate/propagate lookahead adder.
  - Ports a4, b4, cin, s4, cout.
  - Instantiated once, fed with the inverted b nibble.
- Top level contains:
  - FSM and nibble index counter.
  - Operand registers with nibble muxes.
  - Carry flip-flop.
  - diff register with per-nibble write enable.
  - Flag logic.

## Test plan (WIDTH = 16)
- 0x1234 − 0x0234 → diff=0x1000, borrow=0, overflow=0, zero=0; done exactly 4 cycles after the accept edge.
- 0x1000 − 0x0001 → diff=0x0FFF, borrow=0 (borrow ripples through three nibbles); 0x0000 − 0x0001 → diff=0xFFFF, borrow=1.
- 0x8000 − 0x0001 → diff=0x7FFF, overflow=1, borrow=0; 0x7FFF − 0xFFFF → diff=0x8000, overflow=1, borrow=1.
- 0xBEEF − 0xBEEF → diff=0x0000, zero=1, borrow=0; then start=1 during the done cycle with 0x0005 − 0x0003 → busy with no gap, diff=0x0002, done again 4 cycles later.
- start pulsed and a changed during RUN → ignored, result from the originally latched operands; a single done pulse.
- reset asserted mid-RUN, between clock edges → outputs go to 0 immediately and state is IDLE. The next start yields a correct fresh result.
